// File: rtl/ifetch_queue.sv
// Instruction prefetch queue: streams sequential fetch addresses to a single-cycle ROM and
// buffers returned words with their addresses for the CPU fetch port.
module ifetch_queue #(
    parameter int              AW         = 16,
    parameter int              DW         = 24,
    parameter int              DEPTH      = 4,
    parameter logic [AW-1:0]   RESET_ADDR = 16'h0000
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    output logic [AW-1:0] o_rom_addr,
    input  logic [DW-1:0] i_rom_data,
    input  logic          i_redirect,
    input  logic [AW-1:0] i_redirect_addr,
    output logic          o_valid,
    output logic [DW-1:0] o_instr,
    output logic [AW-1:0] o_instr_addr,
    input  logic          i_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] fa_q, fa_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          req_q, req_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [DW-1:0] data_mem_q [DEPTH];
    logic [AW-1:0] addr_mem_q [DEPTH];

    logic          issue;
    logic          push;
    logic          pop;

    // Credit check counts the read in flight so a returning word always has a free slot.
    always_comb begin
        issue = (({1'b0, count_q} + {{CW{1'b0}}, req_q}) < (CW+1)'(DEPTH)) && !i_redirect;
        push  = req_q && !i_redirect;
        pop   = (count_q != '0) && i_ready && !i_redirect;
    end

    always_comb begin
        fa_d     = fa_q;
        addr_d   = addr_q;
        req_d    = req_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_redirect) begin
            fa_d     = i_redirect_addr;
            req_d    = 1'b0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            req_d = issue;
            if (issue) begin
                fa_d   = fa_q + AW'(1);
                addr_d = fa_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fa_q     <= RESET_ADDR;
            addr_q   <= '0;
            req_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_clk_en) begin
            fa_q     <= fa_d;
            addr_q   <= addr_d;
            req_q    <= req_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entries are reset so the head reads as zero until the first word lands.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                data_mem_q[gi] <= '0;
                addr_mem_q[gi] <= '0;
            end else if (i_clk_en && push && (wr_ptr_q == PW'(gi))) begin
                data_mem_q[gi] <= i_rom_data;
                addr_mem_q[gi] <= addr_q;
            end
        end
    end

    assign o_rom_addr   = fa_q;
    assign o_valid      = (count_q != '0);
    assign o_instr      = data_mem_q[rd_ptr_q];
    assign o_instr_addr = addr_mem_q[rd_ptr_q];

endmodule
